issue_ctrl: RTL and testbench

//  Issue/interlock controller between the decode stage and execute. Consumes the decoded

---
 rtl/issue_ctrl.sv | 105 ++++++++++
 tb/tb_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Decode->execute issue interlock: load scoreboard, RAW/WAW stalls, branch-wait/flush FSM.
// Latency: 0-cycle issue when unblocked. Backpressure: stalls decode on ex_ready=0, hazards or load-slot exhaustion.
module issue_ctrl #(
  parameter int NREG   = 16,
  parameter int MAX_LD = 2,
  parameter int LINK   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [3:0] rd,
  input  logic [3:0] rs,
  input  logic [3:0] rt,
  input  logic       is_alu_op,
  input  logic       is_cmp_op,
  input  logic       is_jmp_op,
  input  logic       is_ld_op,
  input  logic       is_str_op,
  input  logic       is_call_op,
  input  logic       is_ret_op,
  input  logic       is_src2_imm,
  input  logic       ex_ready,
  input  logic       ld_done,
  input  logic [3:0] ld_done_rd,
  input  logic       br_resolve,
  input  logic       br_taken,
  output logic       issue_valid,
  output logic       id_ready,
  output logic       stall,
  output logic       flush,
  output logic [2:0] ld_pending
);

  localparam logic [2:0] MAX_LD_C = 3'(MAX_LD);
  localparam logic [3:0] LINK_R   = 4'(LINK);

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic [2:0]        cnt_d;

  logic use_rs, use_rt, use_rd_src, use_link_src, dst_rd, dst_link;
  logic hazard, ld_full, is_ctrl, ld_set, ld_clr;

  always_comb begin
    use_rs       = is_alu_op | is_cmp_op | is_ld_op | is_str_op;
    use_rt       = (is_alu_op | is_cmp_op) & ~is_src2_imm;
    use_rd_src   = is_str_op;
    use_link_src = is_ret_op;
    dst_rd       = is_alu_op | is_ld_op;
    dst_link     = is_call_op;
    is_ctrl      = is_jmp_op | is_call_op | is_ret_op;

    // Registered scoreboard only: a same-cycle writeback does not unblock.
    hazard = (use_rs     & sb_q[rs])
           | (use_rt     & sb_q[rt])
           | ((use_rd_src | dst_rd) & sb_q[rd])
           | ((use_link_src | dst_link) & sb_q[LINK_R]);
    ld_full = is_ld_op & (ld_pending == MAX_LD_C);

    issue_valid = ~reset & id_valid & (state_q == RUN) & ~hazard & ex_ready & ~ld_full;
    id_ready    = issue_valid;
    stall       = ~reset & id_valid & ~issue_valid;
    flush       = (state_q == FLUSH);
  end

  // Scoreboard and outstanding-load count.
  always_comb begin
    ld_set = issue_valid & is_ld_op;
    ld_clr = ld_done & (ld_pending != 3'd0) & sb_q[ld_done_rd];
    sb_d   = sb_q;
    if (ld_clr) sb_d[ld_done_rd] = 1'b0;
    if (ld_set) sb_d[rd] = 1'b1;
    cnt_d = ld_pending;
    case ({ld_set, ld_clr})
      2'b10:   cnt_d = ld_pending + 3'd1;
      2'b01:   cnt_d = ld_pending - 3'd1;
      default: cnt_d = ld_pending;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (issue_valid & is_ctrl) state_d = BR_WAIT;
      BR_WAIT: if (br_resolve) state_d = br_taken ? FLUSH : RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      sb_q       <= '0;
      ld_pending <= 3'd0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      ld_pending <= cnt_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [3:0] rd, rs, rt;
  logic       is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_call_op, is_ret_op, is_src2_imm;
  logic       ex_ready, ld_done, br_resolve, br_taken;
  logic [3:0] ld_done_rd;
  logic       issue_valid, id_ready, stall, flush;
  logic [2:0] ld_pending;

  issue_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .rd(rd), .rs(rs), .rt(rt),
    .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op), .is_ld_op(is_ld_op),
    .is_str_op(is_str_op), .is_call_op(is_call_op), .is_ret_op(is_ret_op), .is_src2_imm(is_src2_imm),
    .ex_ready(ex_ready), .ld_done(ld_done), .ld_done_rd(ld_done_rd),
    .br_resolve(br_resolve), .br_taken(br_taken),
    .issue_valid(issue_valid), .id_ready(id_ready), .stall(stall), .flush(flush),
    .ld_pending(ld_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_NONE, OP_ALU, OP_CMP, OP_JMP, OP_LD, OP_STR, OP_CALL, OP_RET} op_e;

  typedef struct {
    bit       rst;
    bit       vld;
    op_e      op;
    bit [3:0] rd, rs, rt;
    bit       imm;
    bit       exr;
    bit       done;
    bit [3:0] done_rd;
    bit       res;
    bit       tkn;
  } stim_t;

  typedef struct {
    bit iv, st, fl;
    int cnt;
    string tag;
  } exp_t;

  exp_t expq[$];
  int   compared = 0;
  int   mismatched = 0;

  // Reference model: the set of registers awaiting a load result, and where the control path is.
  int       pend[$];
  int       br_phase = 0;   // 0 free, 1 waiting for resolution, 2 flush cycle
  const int LINK_REG = 15;
  const int MAX_LD   = 2;

  function automatic bit is_pend(int r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 0, vld: 0, op: OP_NONE, rd: 0, rs: 0, rt: 0, imm: 0, exr: 1,
          done: 0, done_rd: 0, res: 0, tkn: 0};
    return s;
  endfunction

  function automatic stim_t ins(op_e op, int d, int a, int b, bit imm);
    stim_t s;
    s = idle();
    s.vld = 1; s.op = op; s.rd = 4'(d); s.rs = 4'(a); s.rt = 4'(b); s.imm = imm;
    return s;
  endfunction

  function automatic stim_t with_done(stim_t s, int r);
    stim_t t;
    t = s; t.done = 1; t.done_rd = 4'(r);
    return t;
  endfunction

  function automatic stim_t with_res(stim_t s, bit taken);
    stim_t t;
    t = s; t.res = 1; t.tkn = taken;
    return t;
  endfunction

  task automatic check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle (called #1 after a rising edge), predicts outputs, advances the model.
  task automatic step(stim_t s, string tag);
    exp_t e;
    int   srcs[$];
    int   dsts[$];
    bit   haz;
    reset       = s.rst;
    id_valid    = s.vld;
    rd = s.rd; rs = s.rs; rt = s.rt;
    is_alu_op   = (s.op == OP_ALU);
    is_cmp_op   = (s.op == OP_CMP);
    is_jmp_op   = (s.op == OP_JMP);
    is_ld_op    = (s.op == OP_LD);
    is_str_op   = (s.op == OP_STR);
    is_call_op  = (s.op == OP_CALL);
    is_ret_op   = (s.op == OP_RET);
    is_src2_imm = s.imm;
    ex_ready    = s.exr;
    ld_done     = s.done;
    ld_done_rd  = s.done_rd;
    br_resolve  = s.res;
    br_taken    = s.tkn;

    e.tag = tag;
    if (s.rst) begin
      e.iv = 0; e.st = 0; e.fl = 0; e.cnt = 0;
      expq.push_back(e);
      pend.delete();
      br_phase = 0;
    end else begin
      case (s.op)
        OP_ALU:  begin srcs.push_back(s.rs); if (!s.imm) srcs.push_back(s.rt); dsts.push_back(s.rd); end
        OP_CMP:  begin srcs.push_back(s.rs); if (!s.imm) srcs.push_back(s.rt); end
        OP_LD:   begin srcs.push_back(s.rs); dsts.push_back(s.rd); end
        OP_STR:  begin srcs.push_back(s.rs); srcs.push_back(s.rd); end
        OP_CALL: dsts.push_back(LINK_REG);
        OP_RET:  srcs.push_back(LINK_REG);
        default: ;
      endcase
      haz = 0;
      foreach (srcs[i]) if (is_pend(srcs[i])) haz = 1;
      foreach (dsts[i]) if (is_pend(dsts[i])) haz = 1;
      e.iv  = s.vld && br_phase == 0 && !haz && s.exr &&
              !(s.op == OP_LD && pend.size() == MAX_LD);
      e.st  = s.vld && !e.iv;
      e.fl  = (br_phase == 2);
      e.cnt = pend.size();
      expq.push_back(e);

      if (s.done) begin
        for (int i = 0; i < pend.size(); i++)
          if (pend[i] == int'(s.done_rd)) begin pend.delete(i); break; end
      end
      if (e.iv && s.op == OP_LD) pend.push_back(s.rd);

      if (br_phase == 2) br_phase = 0;
      else if (br_phase == 1) begin
        if (s.res) br_phase = s.tkn ? 2 : 0;
      end else if (e.iv && (s.op == OP_JMP || s.op == OP_CALL || s.op == OP_RET)) br_phase = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check({e.tag, ".issue_valid"}, int'(issue_valid), int'(e.iv));
        check({e.tag, ".id_ready"},    int'(id_ready),    int'(e.iv));
        check({e.tag, ".stall"},       int'(stall),       int'(e.st));
        check({e.tag, ".flush"},       int'(flush),       int'(e.fl));
        check({e.tag, ".ld_pending"},  int'(ld_pending),  e.cnt);
      end
    end
  end

  function automatic bit [3:0] rnd_reg();
    int v;
    v = $urandom_range(0, 7);
    return (v == 7) ? 4'd15 : 4'(v);
  endfunction

  initial begin
    stim_t s, alu;
    reset = 1; id_valid = 0; rd = 0; rs = 0; rt = 0;
    is_alu_op = 0; is_cmp_op = 0; is_jmp_op = 0; is_ld_op = 0; is_str_op = 0;
    is_call_op = 0; is_ret_op = 0; is_src2_imm = 0; ex_ready = 0;
    ld_done = 0; ld_done_rd = 0; br_resolve = 0; br_taken = 0;
    @(posedge clk); #1;
    s = ins(OP_ALU, 1, 2, 3, 0); s.rst = 1;
    step(s, "reset");
    step(s, "reset");

    // Load-use stall until the cycle after writeback.
    step(ins(OP_LD, 3, 0, 0, 0), "t1_ld");
    alu = ins(OP_ALU, 5, 3, 4, 0);
    step(alu, "t1_stall");
    step(alu, "t1_stall");
    step(with_done(alu, 3), "t1_done");
    step(alu, "t1_issue");

    // Load-slot exhaustion.
    step(ins(OP_LD, 1, 0, 0, 0), "t2_ld1");
    step(ins(OP_LD, 2, 0, 0, 0), "t2_ld2");
    step(ins(OP_LD, 6, 0, 0, 0), "t2_full");
    step(with_done(ins(OP_LD, 6, 0, 0, 0), 1), "t2_done");
    step(ins(OP_LD, 6, 0, 0, 0), "t2_issue");
    step(with_done(idle(), 2), "t2_drain");
    step(with_done(idle(), 6), "t2_drain");

    // Immediate second operand masks rt.
    step(ins(OP_LD, 3, 0, 0, 0), "t3_ld");
    step(ins(OP_ALU, 7, 0, 3, 1), "t3_imm");
    step(ins(OP_ALU, 7, 0, 3, 0), "t3_reg");
    step(with_done(idle(), 3), "t3_drain");

    // Branch resolution, taken and not taken.
    step(ins(OP_JMP, 0, 0, 0, 0), "t4_jmp");
    step(ins(OP_ALU, 1, 2, 3, 0), "t4_wait");
    step(idle(), "t4_wait");
    step(with_res(idle(), 1), "t4_taken");
    step(ins(OP_ALU, 1, 2, 3, 0), "t4_flush");
    step(ins(OP_ALU, 1, 2, 3, 0), "t4_run");
    step(with_res(ins(OP_CALL, 0, 0, 0, 0), 1), "t4_call");
    step(with_res(idle(), 0), "t4_ntaken");
    step(ins(OP_RET, 0, 0, 0, 0), "t4_ret");

    // Same-cycle set/clear and spurious writebacks.
    step(with_res(ins(OP_LD, 2, 0, 0, 0), 0), "t5_ld2");
    step(with_done(ins(OP_LD, 4, 0, 0, 0), 2), "t5_swap");
    step(with_done(ins(OP_ALU, 8, 2, 0, 1), 9), "t5_spur");
    step(ins(OP_STR, 4, 0, 0, 0), "t5_strhaz");
    step(with_done(idle(), 4), "t5_done4");
    step(with_done(idle(), 4), "t5_spur0");

    // Reset in BR_WAIT with two loads outstanding.
    step(ins(OP_LD, 1, 0, 0, 0), "t6_ld1");
    step(ins(OP_LD, 2, 0, 0, 0), "t6_ld2");
    step(ins(OP_JMP, 0, 0, 0, 0), "t6_jmp");
    s = ins(OP_ALU, 1, 2, 3, 0); s.rst = 1;
    step(s, "t6_reset");
    step(ins(OP_ALU, 1, 2, 3, 0), "t6_alu");

    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.vld = ($urandom_range(0, 9) < 8);
      s.op  = op_e'($urandom_range(1, 7));
      if ($urandom_range(0, 2) == 0) s.op = OP_LD;
      s.rd  = rnd_reg(); s.rs = rnd_reg(); s.rt = rnd_reg();
      s.imm = $urandom_range(0, 1);
      s.exr = ($urandom_range(0, 9) < 8);
      if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
        s.done = 1; s.done_rd = 4'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        s.done = 1; s.done_rd = rnd_reg();
      end
      s.res = ($urandom_range(0, 9) < 3);
      s.tkn = $urandom_range(0, 1);
      s.rst = ($urandom_range(0, 199) == 0);
      step(s, "rand");
    end

    step(idle(), "final");
    repeat (2) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
